// File: rtl/ps2_kbd_rx.sv
// PS/2 device-to-host receiver: synchronizes ps2_clk/ps2_data, deframes 11-bit frames, queues bytes in a FIFO.
// Optional build macro PS2_PARITY_CHECK_EN additionally rejects frames with bad odd parity.
module ps2_kbd_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_ONE   = TW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

  logic          clk_s1_q, clk_s2_q, clk_prev_q;
  logic          dat_s1_q, dat_s2_q;
  logic          nd_q;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [TW-1:0] timeout_q, timeout_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    last_q, last_d;
  logic [7:0]    fifo_mem [FIFO_DEPTH];

  logic       fall, empty, full, pop, parity_ok, accept, wr_en;
  logic [7:0] head;

  // shift_q holds {parity, d7..d0, start} once ten bits are in
`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^shift_q[9:1];
`else
  assign parity_ok = 1'b1;
`endif

  assign fall   = clk_prev_q & ~clk_s2_q;
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head   = fifo_mem[rd_ptr_q[AW-1:0]];
  assign pop    = nd_q & ~nextdata_n & ~empty;
  assign accept = fall && (bit_cnt_q == 4'd10) && !shift_q[0] && dat_s2_q && parity_ok;
  assign wr_en  = accept & ~full;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    timeout_d = timeout_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ovf_d     = ovf_q | (accept & full);
    last_d    = last_q;

    if (fall) begin
      timeout_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
      end else begin
        shift_d   = {dat_s2_q, shift_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      // A stalled partial frame is dropped silently so the next start bit realigns
      if (timeout_q == TO_LIMIT) begin
        bit_cnt_d = 4'd0;
        timeout_d = '0;
      end else begin
        timeout_d = timeout_q + TO_ONE;
      end
    end else begin
      timeout_d = '0;
    end

    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      last_d   = head;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) fifo_mem[wr_ptr_q[AW-1:0]] <= shift_q[8:1];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      nd_q       <= 1'b1;
      bit_cnt_q  <= 4'd0;
      shift_q    <= '0;
      timeout_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ovf_q      <= 1'b0;
      last_q     <= 8'h00;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data;
      dat_s2_q   <= dat_s1_q;
      nd_q       <= nextdata_n;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      timeout_q  <= timeout_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_q      <= ovf_d;
      last_q     <= last_d;
    end
  end

  // Once drained, the consumer keeps seeing the byte it popped last
  assign data     = empty ? last_q : head;
  assign ready    = ~empty;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: stimulus pushes expected bytes, a monitor checks them at each pop strobe.
module tb_ps2_kbd_rx;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q [$];

  always #5 clock = ~clock;

  ps2_kbd_rx dut (
    .clock      (clock),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    nextdata_n = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(2);
    $display("reset");
  endtask

  task automatic do_pop();
    wait_cyc(1);
    nextdata_n = 1'b0;
    wait_cyc(2);
    nextdata_n = 1'b1;
    wait_cyc(2);
  endtask

  // pww issues a pop strobe that lands on the same clock as the FIFO write
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input bit measure, input bit pww);
    logic [10:0] fr;
    int lat;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    lat = 0;
    for (int i = 0; i < nbits; i++) begin
      wait_cyc(1);
      ps2_data = fr[i];
      wait_cyc(3);
      ps2_clk = 1'b0;
      if (i == 10) begin
        for (int c = 1; c <= 6; c++) begin
          wait_cyc(1);
          if (pww && c == 2) nextdata_n = 1'b0;
          if (pww && c == 4) nextdata_n = 1'b1;
          if (lat == 0 && ready) lat = c;
        end
      end else begin
        wait_cyc(5);
      end
      ps2_clk = 1'b1;
      wait_cyc(2);
    end
    ps2_data = 1'b1;
    wait_cyc(2);
    $display("send 0x%02h bits=%0d bad_par=%0d bad_stop=%0d pop_with_write=%0d", b, nbits, bad_par, bad_stop, pww);
    if (measure) chk("ready_latency_le_4", (lat > 0 && lat <= 4), 1);
  endtask

  // Monitor: each high-to-low nextdata_n with data pending consumes one expected byte
  initial begin
    logic nd_prev;
    logic [7:0] e;
    nd_prev = 1'b1;
    forever begin
      @(negedge clock);
      if (reset) begin
        nd_prev = 1'b1;
      end else begin
        if (nd_prev && !nextdata_n) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            $display("pop data=0x%02h expected=0x%02h ready=%0d", data, e, ready);
            chk("pop_ready", ready, 1);
            chk("pop_data", data, e);
          end else begin
            $display("pop on empty ready=%0d", ready);
            chk("pop_empty_ready", ready, 0);
          end
        end
        nd_prev = nextdata_n;
      end
    end
  end

  initial begin
    do_reset();
    chk("reset_data", data, 8'h00);
    chk("reset_ready", ready, 0);
    chk("reset_overflow", overflow, 0);

    send_frame(8'h1C, 0, 0, 11, 1, 0);
    exp_q.push_back(8'h1C);
    chk("t1_data", data, 8'h1C);
    chk("t1_overflow", overflow, 0);
    do_pop();
    chk("t1_ready_after_pop", ready, 0);

    send_frame(8'h1C, 0, 0, 11, 0, 0); exp_q.push_back(8'h1C);
    send_frame(8'hF0, 0, 0, 11, 0, 0); exp_q.push_back(8'hF0);
    send_frame(8'h1C, 0, 0, 11, 0, 0); exp_q.push_back(8'h1C);
    chk("t2_head", data, 8'h1C);
    repeat (3) do_pop();
    chk("t2_ready_drained", ready, 0);
    do_pop();
    chk("t2_extra_pop_data", data, 8'h1C);
    chk("t2_extra_pop_ready", ready, 0);

    for (int i = 0; i < 9; i++) begin
      send_frame(8'h1B, 0, 0, 11, 0, 0);
      if (i < 8) exp_q.push_back(8'h1B);
      if (i == 7) chk("t3_no_overflow_at_8", overflow, 0);
    end
    chk("t3_overflow_at_9", overflow, 1);
    repeat (8) do_pop();
    chk("t3_ready_drained", ready, 0);
    chk("t3_overflow_sticky", overflow, 1);

    send_frame(8'h2A, 0, 1, 11, 0, 0);
    chk("bad_stop_ready", ready, 0);

    send_frame(8'h1C, 1, 0, 11, 0, 0);
`ifdef PS2_PARITY_CHECK_EN
    chk("bad_parity_dropped", ready, 0);
`else
    chk("bad_parity_kept", data, 8'h1C);
    exp_q.push_back(8'h1C);
    do_pop();
`endif
    chk("bad_parity_ready_end", ready, 0);

    do_reset();
    chk("reset2_overflow", overflow, 0);
    for (int i = 1; i <= 7; i++) begin
      send_frame(8'(i), 0, 0, 11, 0, 0);
      exp_q.push_back(8'(i));
    end
    for (int k = 0; k < 6; k++) begin
      send_frame(8'h10 + 8'(k), 0, 0, 11, 0, 1);
      exp_q.push_back(8'h10 + 8'(k));
    end
    send_frame(8'h20, 0, 0, 11, 0, 0);
    exp_q.push_back(8'h20);
    chk("concurrent_full_ready", ready, 1);
    chk("concurrent_no_overflow", overflow, 0);
    repeat (8) do_pop();
    chk("concurrent_drained", ready, 0);

    send_frame(8'h55, 0, 0, 5, 0, 0);
    wait_cyc(4200);
    send_frame(8'h1B, 0, 0, 11, 0, 0);
    exp_q.push_back(8'h1B);
    chk("timeout_data", data, 8'h1B);
    do_pop();
    chk("timeout_only_one", ready, 0);

    send_frame(8'h55, 0, 0, 5, 0, 0);
    do_reset();
    send_frame(8'h1B, 0, 0, 11, 0, 0);
    exp_q.push_back(8'h1B);
    chk("midreset_data", data, 8'h1B);
    do_pop();
    chk("midreset_only_one", ready, 0);

    wait_cyc(3);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
